// File: rtl/me_pkg.sv
// Shared constants and types for the full-search block motion estimator.
// The search runs 4112 cycles: 4096 pixel fetches plus 16 cycles to drain the PE skew.
package me_pkg;

    localparam int PIX_W        = 8;
    localparam int BLK          = 16;
    localparam int ACC_W        = 16;
    localparam int S_ROW_PITCH  = 32;
    localparam int TOTAL_CYCLES = 4112;
    localparam int CNT_W        = 13;  // has to reach TOTAL_CYCLES-1 = 4111

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    function automatic logic [PIX_W-1:0] sat_pix(input logic [ACC_W-1:0] v);
        return (|v[ACC_W-1:PIX_W]) ? {PIX_W{1'b1}} : v[PIX_W-1:0];
    endfunction

endpackage

// File: rtl/me_pe.sv
// One processing element: accumulates |R - S| for candidate column offset K
// over one 256-pixel pass and strobes done_o on the pass's last pixel.
module me_pe
    import me_pkg::*;
#(
    parameter int K = 0
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             d_valid_i,
    input  logic [CNT_W-1:0] d_idx_i,
    input  logic [PIX_W-1:0] r_i,
    input  logic [PIX_W-1:0] s1_i,
    input  logic [PIX_W-1:0] s2_i,
    output logic [ACC_W-1:0] sad_o,
    output logic [3:0]       dy_o,
    output logic             done_o
);

    // Pixel number seen by this PE; the extra top bit flags d_idx_i < K.
    logic [CNT_W:0]   m;
    logic             active;
    logic             sel_s1;
    logic [PIX_W-1:0] s_pix;
    logic [PIX_W-1:0] diff;
    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] sum;

    assign m      = {1'b0, d_idx_i} - (CNT_W+1)'(K);
    assign active = d_valid_i && (m[CNT_W:CNT_W-1] == 2'b00);

    // Columns to the left of K borrowed from the previous row: those come from port 2.
    if (K == 0) begin : g_sel_k0
        assign sel_s1 = 1'b1;
    end else begin : g_sel_kn
        assign sel_s1 = d_idx_i[3:0] >= 4'(K);
    end

    assign s_pix = sel_s1 ? s1_i : s2_i;
    assign diff  = (r_i >= s_pix) ? r_i - s_pix : s_pix - r_i;
    assign sum   = ((m[7:0] == 8'd0) ? '0 : acc_q) + ACC_W'(diff);

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (active) begin
            acc_q <= sum;
        end
    end

    assign sad_o  = sum;
    assign dy_o   = m[11:8];
    assign done_o = active && (m[7:0] == 8'hFF);

endmodule

// File: rtl/block_motion_estimator.sv
// Full-search block matcher: sweeps 16x16 candidates of a 31x31 window with
// 16 skewed PEs and keeps the first candidate with the smallest SAD.
module block_motion_estimator
    import me_pkg::*;
(
    input  logic             clock,
    input  logic             rst_n,
    input  logic             start,
    input  logic [PIX_W-1:0] R,
    input  logic [PIX_W-1:0] S1,
    input  logic [PIX_W-1:0] S2,
    output logic [PIX_W-1:0] BestDist,
    output logic [3:0]       motionX,
    output logic [3:0]       motionY,
    output logic [7:0]       AddressR,
    output logic [9:0]       AddressS1,
    output logic [9:0]       AddressS2
);

    state_e           state_q;
    logic [CNT_W-1:0] c_q;
    logic [ACC_W-1:0] best_q;
    logic [PIX_W-1:0] best_dist_q;
    logic [3:0]       motion_x_q;
    logic [3:0]       motion_y_q;

    logic             run;
    logic [7:0]       q_row;
    logic [4:0]       s1_row;
    logic [4:0]       s2_row;
    logic             d_valid;
    logic [CNT_W-1:0] d_idx;

    logic [PIX_W-1:0] r_dly_q [BLK-1];
    logic [ACC_W-1:0] pe_sad  [BLK];
    logic [3:0]       pe_dy   [BLK];
    logic [BLK-1:0]   pe_done;

    logic             hit;
    logic [ACC_W-1:0] hit_sad;
    logic [3:0]       hit_dx;
    logic [3:0]       hit_dy;

    assign run    = (state_q == RUN);
    assign q_row  = c_q[11:4] - 8'd1;
    assign s1_row = {1'b0, c_q[11:8]} + {1'b0, c_q[7:4]};
    assign s2_row = {1'b0, q_row[7:4]} + {1'b0, q_row[3:0]};

    // Row pitch is 32, so row*32 + col is a concatenation; bit 4 adds the +16 for port 2.
    assign AddressR  = run ? c_q[7:0] : '0;
    assign AddressS1 = run ? {s1_row, 1'b0, c_q[3:0]} : '0;
    assign AddressS2 = run ? {s2_row, 1'b1, c_q[3:0]} : '0;

    // ROM data returning this cycle belongs to fetch index c_q - 1.
    assign d_valid = run && (c_q != '0);
    assign d_idx   = c_q - CNT_W'(1);

    // NOTE: pure datapath delay line, left without reset; each PE clears its
    // accumulator on pixel 0, by which time its tap holds valid data.
    always_ff @(posedge clock) begin
        r_dly_q[0] <= R;
        for (int k = 1; k < BLK-1; k++) begin
            r_dly_q[k] <= r_dly_q[k-1];
        end
    end

    for (genvar k = 0; k < BLK; k++) begin : g_pe
        logic [PIX_W-1:0] r_tap;
        if (k == 0) begin : g_tap0
            assign r_tap = R;
        end else begin : g_tapn
            assign r_tap = r_dly_q[k-1];
        end

        me_pe #(.K(k)) u_pe (
            .clock     (clock),
            .rst_n     (rst_n),
            .d_valid_i (d_valid),
            .d_idx_i   (d_idx),
            .r_i       (r_tap),
            .s1_i      (S1),
            .s2_i      (S2),
            .sad_o     (pe_sad[k]),
            .dy_o      (pe_dy[k]),
            .done_o    (pe_done[k])
        );
    end

    // The PE skew guarantees at most one done strobe per cycle.
    // NOTE: every output gets a default first so no latch is inferred.
    always_comb begin
        hit     = 1'b0;
        hit_sad = '0;
        hit_dx  = '0;
        hit_dy  = '0;
        for (int k = 0; k < BLK; k++) begin
            if (pe_done[k]) begin
                hit     = 1'b1;
                hit_sad = pe_sad[k];
                hit_dx  = 4'(k);
                hit_dy  = pe_dy[k];
            end
        end
    end

    // NOTE: all state here is updated with non-blocking assignments so every
    // register samples the pre-edge values of the others.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            c_q         <= '0;
            best_q      <= '1;
            best_dist_q <= '1;
            motion_x_q  <= '0;
            motion_y_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q     <= RUN;
                        c_q         <= '0;
                        best_q      <= '1;
                        best_dist_q <= '1;
                        motion_x_q  <= '0;
                        motion_y_q  <= '0;
                    end
                end
                RUN: begin
                    // Strict less-than keeps the earliest candidate on ties.
                    if (hit && (hit_sad < best_q)) begin
                        best_q      <= hit_sad;
                        best_dist_q <= sat_pix(hit_sad);
                        motion_x_q  <= hit_dx;
                        motion_y_q  <= hit_dy;
                    end
                    if (c_q == CNT_W'(TOTAL_CYCLES-1)) begin
                        state_q <= DONE;
                    end else begin
                        c_q <= c_q + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (!start) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign BestDist = best_dist_q;
    assign motionX  = motion_x_q;
    assign motionY  = motion_y_q;

endmodule

// File: tb/tb_block_motion_estimator.sv
// Self-checking bench: synchronous ROM models, a reference full search and an
// expected-result queue consumed when each search completes.
module tb_block_motion_estimator;

    localparam int RUN_CYCLES = 4112;

    typedef struct packed {
        logic [7:0] bd;
        logic [3:0] mx;
        logic [3:0] my;
    } res_t;

    logic       clock = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] R;
    logic [7:0] S1;
    logic [7:0] S2;
    logic [7:0] BestDist;
    logic [3:0] motionX;
    logic [3:0] motionY;
    logic [7:0] AddressR;
    logic [9:0] AddressS1;
    logic [9:0] AddressS2;

    logic [7:0] rom_r [256];
    logic [7:0] rom_s [1024];

    res_t exp_q [$];
    int   checks = 0;
    int   errors = 0;

    block_motion_estimator dut (
        .clock     (clock),
        .rst_n     (rst_n),
        .start     (start),
        .R         (R),
        .S1        (S1),
        .S2        (S2),
        .BestDist  (BestDist),
        .motionX   (motionX),
        .motionY   (motionY),
        .AddressR  (AddressR),
        .AddressS1 (AddressS1),
        .AddressS2 (AddressS2)
    );

    always #5 clock = ~clock;

    always_ff @(posedge clock) begin
        R  <= rom_r[AddressR];
        S1 <= rom_s[AddressS1];
        S2 <= rom_s[AddressS2];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic check_result(input string tag, input res_t e);
        check({tag, "_bestdist"}, 32'(BestDist), 32'(e.bd));
        check({tag, "_motionx"},  32'(motionX),  32'(e.mx));
        check({tag, "_motiony"},  32'(motionY),  32'(e.my));
    endtask

    // Expected {AddressR, AddressS1, AddressS2} during run cycle c.
    function automatic logic [27:0] exp_addr(input int c);
        int ar, dy, row, col, q, s1, s2;
        ar  = c % 256;
        dy  = (c >> 8) & 15;
        row = (c >> 4) & 15;
        col = c & 15;
        s1  = 32 * (dy + row) + col;
        q   = ((c >> 4) - 1) & 255;
        s2  = 32 * ((q >> 4) + (q & 15)) + col + 16;
        return {ar[7:0], s1[9:0], s2[9:0]};
    endfunction

    // Reference full search, scanning dy then dx so the first minimum wins.
    function automatic res_t model_search();
        int   best;
        int   sad;
        int   a;
        int   b;
        res_t r;
        best = 65535;
        r    = '{bd: 8'hFF, mx: 4'd0, my: 4'd0};
        for (int dy = 0; dy < 16; dy++) begin
            for (int dx = 0; dx < 16; dx++) begin
                sad = 0;
                for (int row = 0; row < 16; row++) begin
                    for (int col = 0; col < 16; col++) begin
                        a = int'(rom_r[row*16 + col]);
                        b = int'(rom_s[(dy + row)*32 + dx + col]);
                        sad += (a > b) ? a - b : b - a;
                    end
                end
                if (sad < best) begin
                    best = sad;
                    r.mx = 4'(dx);
                    r.my = 4'(dy);
                end
            end
        end
        r.bd = (best > 255) ? 8'hFF : 8'(best);
        return r;
    endfunction

    task automatic fill(input int r_val, input int s_val);
        for (int i = 0; i < 256; i++)  rom_r[i] = 8'(r_val);
        for (int i = 0; i < 1024; i++) rom_s[i] = 8'(s_val);
    endtask

    task automatic fill_random(input int max_val);
        for (int i = 0; i < 256; i++)  rom_r[i] = 8'($urandom_range(0, max_val));
        for (int i = 0; i < 1024; i++) rom_s[i] = 8'($urandom_range(0, max_val));
    endtask

    task automatic plant(input int dx, input int dy);
        for (int row = 0; row < 16; row++)
            for (int col = 0; col < 16; col++)
                rom_s[(dy + row)*32 + dx + col] = rom_r[row*16 + col];
    endtask

    // Called at a negedge with the DUT able to accept start on the next edge.
    task automatic run_search(input string tag, input bit chk_addr);
        res_t e;
        start = 1'b1;
        for (int c = 0; c < RUN_CYCLES; c++) begin
            @(posedge clock);
            @(negedge clock);
            if (chk_addr)
                check({tag, "_addr"}, 32'({AddressR, AddressS1, AddressS2}), 32'(exp_addr(c)));
        end
        e = exp_q.pop_front();
        check_result(tag, e);
    endtask

    task automatic idle_cycles(input int n);
        start = 1'b0;
        repeat (n) @(negedge clock);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_addr_idle"}, 32'({AddressR, AddressS1, AddressS2}), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        fill(0, 0);
        repeat (2) @(negedge clock);
        check_result("reset", '{bd: 8'hFF, mx: 4'd0, my: 4'd0});
        check_idle_outputs("reset");
        rst_n = 1'b1;
        @(negedge clock);

        // Exact match of R planted at dx=5, dy=3 in random data.
        fill_random(255);
        plant(5, 3);
        exp_q.push_back('{bd: 8'd0, mx: 4'd5, my: 4'd3});
        run_search("match", 1'b1);

        // start still high: DONE must hold and not restart.
        repeat (20) @(negedge clock);
        check_result("hold", '{bd: 8'd0, mx: 4'd5, my: 4'd3});
        check_idle_outputs("hold");

        idle_cycles(2);
        exp_q.push_back('{bd: 8'd0, mx: 4'd5, my: 4'd3});
        run_search("rerun", 1'b0);
        idle_cycles(2);

        // Every candidate ties at zero; the first one must win.
        fill(8'h40, 8'h40);
        exp_q.push_back('{bd: 8'd0, mx: 4'd0, my: 4'd0});
        run_search("flat", 1'b0);
        idle_cycles(2);

        // Every SAD is 65280; BestDist saturates.
        fill(255, 0);
        exp_q.push_back('{bd: 8'hFF, mx: 4'd0, my: 4'd0});
        run_search("saturate", 1'b0);
        idle_cycles(2);

        // Binary pixels give small, often tied SADs; abort mid-run, then rerun.
        fill_random(1);
        exp_q.push_back(model_search());
        start = 1'b1;
        repeat (2001) @(posedge clock);
        @(negedge clock);
        check("abort_addr_c2000", 32'({AddressR, AddressS1, AddressS2}), 32'(exp_addr(2000)));
        rst_n = 1'b0;
        #1;
        check_result("abort", '{bd: 8'hFF, mx: 4'd0, my: 4'd0});
        check_idle_outputs("abort");
        @(negedge clock);
        rst_n = 1'b1;
        run_search("after_reset", 1'b0);
        idle_cycles(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
